// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared pipeline types and forwarding select encodings
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } fsm_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// rtl/pipe_hazard_ctrl_fwd_unit.sv - combinational EX-stage operand forwarding selects
module fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1_E,
  input  logic [4:0] rs2_E,
  input  logic [4:0] rd_M,
  input  logic [4:0] rd_W,
  input  logic       reg_wr_M,
  input  logic       sel_wb_M,
  input  logic       reg_wr_W,
  output logic [1:0] fwd_a_E,
  output logic [1:0] fwd_b_E
);

  logic mem_src_ok;
  logic wb_src_ok;

  // A load in MEM has no data yet, so it cannot feed the EX bypass.
  assign mem_src_ok = reg_wr_M && !sel_wb_M && (rd_M != 5'd0);
  assign wb_src_ok  = reg_wr_W && (rd_W != 5'd0);

  assign fwd_a_E = (mem_src_ok && (rd_M == rs1_E)) ? FWD_MEM :
                   (wb_src_ok  && (rd_W == rs1_E)) ? FWD_WB  : FWD_RF;

  assign fwd_b_E = (mem_src_ok && (rd_M == rs2_E)) ? FWD_MEM :
                   (wb_src_ok  && (rd_W == rs2_E)) ? FWD_WB  : FWD_RF;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush control, memory-wait FSM and forwarding
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic        use_rs1_D,
  input  logic        use_rs2_D,
  input  logic [4:0]  rs1_E,
  input  logic [4:0]  rs2_E,
  input  logic [4:0]  rd_E,
  input  logic        reg_wr_E,
  input  logic        sel_wb_E,
  input  logic [4:0]  rd_M,
  input  logic [4:0]  rd_W,
  input  logic        reg_wr_M,
  input  logic        sel_wb_M,
  input  logic        reg_wr_W,
  input  logic        branch_taken_E,
  input  logic        dmem_req_M,
  input  logic        dmem_ready,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        stall_M,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_W,
  output logic [1:0]  fwd_a_E,
  output logic [1:0]  fwd_b_E,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  fsm_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;
  logic          timeout_hit;
  logic          mw;
  logic          lu;
  logic          halted;

  fwd_unit u_fwd (
    .rs1_E    (rs1_E),
    .rs2_E    (rs2_E),
    .rd_M     (rd_M),
    .rd_W     (rd_W),
    .reg_wr_M (reg_wr_M),
    .sel_wb_M (sel_wb_M),
    .reg_wr_W (reg_wr_W),
    .fwd_a_E  (fwd_a_E),
    .fwd_b_E  (fwd_b_E)
  );

  assign halted = (state == HALT);
  assign mw     = ((state == IDLE) && dmem_req_M && !dmem_ready) ||
                  ((state == MEM_WAIT) && !dmem_ready);
  assign lu     = reg_wr_E && sel_wb_E && (rd_E != 5'd0) &&
                  ((use_rs1_D && (rd_E == rs1_D)) || (use_rs2_D && (rd_E == rs2_D)));

  assign wait_nxt    = wait_cnt + CW'(1);
  assign timeout_hit = (wait_nxt == CW'(MEM_TIMEOUT));

  // Priority: HALT > memory wait > branch > load-use; reset forces everything quiet.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (rst_n) begin
      if (halted || mw) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (branch_taken_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (lu) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (stall_F) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (mw) begin
        wait_cnt <= wait_nxt;
        if (timeout_hit) begin
          state       <= HALT;
          mem_timeout <= 1'b1;
        end else if (state == IDLE) begin
          state <= MEM_WAIT;
        end
      end else begin
        wait_cnt <= '0;
        // Outside HALT, no wait means any outstanding access just completed.
        if (state == MEM_WAIT) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl against a behavioural pipeline model
module tb_pipe_hazard_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic        use_rs1_D, use_rs2_D, reg_wr_E, sel_wb_E;
  logic        reg_wr_M, sel_wb_M, reg_wr_W, branch_taken_E;
  logic        dmem_req_M, dmem_ready;
  logic        stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E, flush_W;
  logic [1:0]  fwd_a_E, fwd_b_E;
  logic        mem_timeout;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .reg_wr_E(reg_wr_E), .sel_wb_E(sel_wb_E),
    .rd_M(rd_M), .rd_W(rd_W), .reg_wr_M(reg_wr_M), .sel_wb_M(sel_wb_M), .reg_wr_W(reg_wr_W),
    .branch_taken_E(branch_taken_E), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       use1, use2, reg_wr_E, sel_wb_E, reg_wr_M, sel_wb_M, reg_wr_W;
    logic       br, req, rdy;
  } stim_t;

  typedef struct packed {
    logic [10:0] ctrl;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model: an outstanding access, how many edges it has been waiting, halt status.
  bit          m_wait, m_halt, m_err, cur_rst;
  int          m_waited;
  logic [31:0] m_cnt;
  bit          prev_stall_f, prev_mw;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [1:0] producer(input logic [4:0] rs, input stim_t s);
    if (rs == 0) return 2'b00;
    if (s.reg_wr_M && !s.sel_wb_M && s.rd_M == rs) return 2'b10;
    if (s.reg_wr_W && s.rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = '{rst: 1'b1, default: '0};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bit lu, mw;
    bit sf, sd, se, sm, fd, fe, fw;
    exp_t e;
    @(posedge clk);
    #1;
    if (cur_rst) begin
      if (prev_stall_f) m_cnt++;
      if (!m_halt) begin
        if (prev_mw) begin
          m_waited++;
          m_wait = 1;
          if (m_waited == TMO) begin
            m_halt = 1;
            m_err  = 1;
          end
        end else begin
          m_waited = 0;
          m_wait   = 0;
        end
      end
    end
    rst_n = s.rst; rs1_D = s.rs1_D; rs2_D = s.rs2_D; use_rs1_D = s.use1; use_rs2_D = s.use2;
    rs1_E = s.rs1_E; rs2_E = s.rs2_E; rd_E = s.rd_E; reg_wr_E = s.reg_wr_E; sel_wb_E = s.sel_wb_E;
    rd_M = s.rd_M; rd_W = s.rd_W; reg_wr_M = s.reg_wr_M; sel_wb_M = s.sel_wb_M; reg_wr_W = s.reg_wr_W;
    branch_taken_E = s.br; dmem_req_M = s.req; dmem_ready = s.rdy;
    cur_rst = s.rst;
    if (!s.rst) begin
      m_wait = 0; m_waited = 0; m_halt = 0; m_err = 0; m_cnt = 0;
    end
    lu = s.reg_wr_E && s.sel_wb_E && s.rd_E != 0 &&
         ((s.use1 && s.rd_E == s.rs1_D) || (s.use2 && s.rd_E == s.rs2_D));
    mw = s.rst && !m_halt && !s.rdy && (m_wait || s.req);
    {sf, sd, se, sm, fd, fe, fw} = '0;
    if (!s.rst) begin
      {sf, sd, se, sm, fd, fe, fw} = '0;
    end else if (m_halt || mw) begin
      {sf, sd, se, sm, fw} = 5'b11111;
    end else if (s.br) begin
      {fd, fe} = 2'b11;
    end else if (lu) begin
      {sf, sd, fe} = 3'b111;
    end
    e.ctrl = {sf, sd, se, sm, fd, fe, fw, producer(s.rs1_E, s), producer(s.rs2_E, s)};
    e.err  = m_err;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
    prev_stall_f = sf;
    prev_mw      = mw;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctrl", 32'({stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
                         fwd_a_E, fwd_b_E}), 32'(e.ctrl));
      check("mem_timeout", 32'(mem_timeout), 32'(e.err));
      check("stall_cnt", stall_cnt, e.cnt);
    end
  end

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 3));
  endfunction

  initial begin
    stim_t s;
    rst_n = 1'b0;
    {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
    {use_rs1_D, use_rs2_D, reg_wr_E, sel_wb_E, reg_wr_M, sel_wb_M, reg_wr_W} = '0;
    {branch_taken_E, dmem_req_M, dmem_ready} = '0;
    cur_rst = 0; m_wait = 0; m_waited = 0; m_halt = 0; m_err = 0; m_cnt = 0;
    prev_stall_f = 0; prev_mw = 0;

    s = quiet(); s.rst = 1'b0;
    apply(s); apply(s);
    s = quiet();
    apply(s);
    // load-use on x5, then its suppressed variants
    s.reg_wr_E = 1; s.sel_wb_E = 1; s.rd_E = 5; s.rs1_D = 5; s.use1 = 1;
    apply(s);
    s = quiet(); apply(s);
    s.reg_wr_E = 1; s.sel_wb_E = 1; s.rd_E = 0; s.rs1_D = 0; s.use1 = 1; apply(s);
    s.rd_E = 5; s.rs1_D = 5; s.use1 = 0; apply(s);
    s.use1 = 1; s.br = 1; apply(s);
    // three wait cycles then ready
    s = quiet(); s.req = 1;
    repeat (3) apply(s);
    s.rdy = 1; apply(s);
    s = quiet(); apply(s);
    // forwarding priority
    s.rd_M = 7; s.rd_W = 7; s.rs1_E = 7; s.reg_wr_M = 1; s.reg_wr_W = 1; apply(s);
    s.sel_wb_M = 1; apply(s);
    s.sel_wb_M = 0; s.rs2_E = 0; apply(s);
    // timeout into HALT, then reset pulse
    s = quiet(); s.req = 1;
    repeat (7) apply(s);
    s.rst = 0; apply(s);
    s = quiet(); apply(s);

    for (int i = 0; i < 3000; i++) begin
      s.rst      = ($urandom_range(0, 59) != 0);
      s.rs1_D    = rreg(); s.rs2_D = rreg(); s.rs1_E = rreg(); s.rs2_E = rreg();
      s.rd_E     = rreg(); s.rd_M  = rreg(); s.rd_W  = rreg();
      s.use1     = 1'($urandom); s.use2 = 1'($urandom);
      s.reg_wr_E = 1'($urandom); s.sel_wb_E = 1'($urandom);
      s.reg_wr_M = 1'($urandom); s.sel_wb_M = 1'($urandom); s.reg_wr_W = 1'($urandom);
      s.br       = ($urandom_range(0, 4) == 0);
      s.req      = 1'($urandom);
      s.rdy      = ($urandom_range(0, 9) < 6);
      apply(s);
    end

    @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
